// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch / writeback controller.
package operand_fetch_pkg;

    localparam int AW     = 5;
    localparam int DATA_W = 32;

    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Issue, operand, writeback and register-file buses of the operand fetch block.
interface operand_fetch_if #(
    parameter int W = operand_fetch_pkg::DATA_W
);
    import operand_fetch_pkg::*;

    logic          iss_valid;
    logic          iss_ready;
    logic [AW-1:0] iss_rs;
    logic [AW-1:0] iss_rt;
    logic [AW-1:0] iss_rd;
    logic          iss_wr;

    logic          op_valid;
    logic          op_ready;
    logic [W-1:0]  op_rsd;
    logic [W-1:0]  op_rtd;
    logic [AW-1:0] op_rd;
    logic          op_wr;

    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;

    logic [AW-1:0] rsa;
    logic [AW-1:0] rta;
    logic [W-1:0]  rsd;
    logic [W-1:0]  rtd;
    logic [AW-1:0] wta;
    logic [W-1:0]  wtd;
    logic          cnt;

    // Pipeline and register file side.
    modport master (
        output iss_valid, iss_rs, iss_rt, iss_rd, iss_wr,
        output op_ready,
        output wb_valid, wb_addr, wb_data,
        output rsd, rtd,
        input  iss_ready,
        input  op_valid, op_rsd, op_rtd, op_rd, op_wr,
        input  rsa, rta, wta, wtd, cnt
    );

    // Operand fetch controller side.
    modport slave (
        input  iss_valid, iss_rs, iss_rt, iss_rd, iss_wr,
        input  op_ready,
        input  wb_valid, wb_addr, wb_data,
        input  rsd, rtd,
        output iss_ready,
        output op_valid, op_rsd, op_rtd, op_rd, op_wr,
        output rsa, rta, wta, wtd, cnt
    );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding write, flags
// RAW/WAW hazards and reports writebacks that arrive for idle registers.
module operand_fetch_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic [AW-1:0] rd,
    input  logic          rd_wr,
    output logic          rs_fwd,
    output logic          rt_fwd,
    output logic          raw_haz,
    output logic          waw_haz,
    output logic          sb_err
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            rd_clr;
    logic            idle_wb;

    // A writeback landing this cycle resolves the dependency it targets.
    always_comb begin
        rs_fwd  = clr_en && (clr_addr == rs) && (rs != ZERO_REG);
        rt_fwd  = clr_en && (clr_addr == rt) && (rt != ZERO_REG);
        rd_clr  = clr_en && (clr_addr == rd);
        raw_haz = (busy_q[rs] && !rs_fwd) || (busy_q[rt] && !rt_fwd);
        waw_haz = rd_wr && (rd != ZERO_REG) && busy_q[rd] && !rd_clr;
        idle_wb = clr_en && (clr_addr != ZERO_REG) && !busy_q[clr_addr];
    end

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != ZERO_REG)) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            sb_err <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (idle_wb) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch and writeback controller: drives register-file ports, selects
// operands (zero / forward / file), and registers one bundle toward the pipeline.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int W    = DATA_W,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    operand_fetch_if.slave bus,
    output logic          sb_err,
    output logic [15:0]   stall_cnt
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    ostate_t       state_q;
    ostate_t       state_d;
    logic          rs_fwd;
    logic          rt_fwd;
    logic          raw_haz;
    logic          waw_haz;
    logic          hazard;
    logic          iss_ready;
    logic          accept;
    logic [W-1:0]  rsd_p0;
    logic [W-1:0]  rtd_p0;
    logic [W-1:0]  rsd_p1;
    logic [W-1:0]  rtd_p1;
    logic [AW-1:0] rd_p1;
    logic          wr_p1;
    logic [15:0]   stall_q;

    assign bus.rsa = bus.iss_rs;
    assign bus.rta = bus.iss_rt;
    assign bus.wta = bus.wb_addr;
    assign bus.wtd = bus.wb_data;
    assign bus.cnt = bus.wb_valid && (bus.wb_addr != ZERO_REG);

    operand_fetch_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (accept && bus.iss_wr),
        .set_addr (bus.iss_rd),
        .clr_en   (bus.wb_valid),
        .clr_addr (bus.wb_addr),
        .rs       (bus.iss_rs),
        .rt       (bus.iss_rt),
        .rd       (bus.iss_rd),
        .rd_wr    (bus.iss_wr),
        .rs_fwd   (rs_fwd),
        .rt_fwd   (rt_fwd),
        .raw_haz  (raw_haz),
        .waw_haz  (waw_haz),
        .sb_err   (sb_err)
    );

    // p0: operand select
    always_comb begin
        rsd_p0 = bus.rsd;
        rtd_p0 = bus.rtd;
        if (bus.iss_rs == ZERO_REG) begin
            rsd_p0 = '0;
        end else if (rs_fwd) begin
            rsd_p0 = bus.wb_data;
        end
        if (bus.iss_rt == ZERO_REG) begin
            rtd_p0 = '0;
        end else if (rt_fwd) begin
            rtd_p0 = bus.wb_data;
        end
    end

    always_comb begin
        hazard    = raw_haz || waw_haz;
        iss_ready = !hazard && ((state_q == EMPTY) || bus.op_ready);
        accept    = bus.iss_valid && iss_ready;
    end

    assign bus.iss_ready = iss_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.op_ready && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (bus.iss_valid && hazard) begin
                stall_q <= sat_inc(stall_q);
            end
        end
    end

    // p1: registered operand bundle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsd_p1 <= '0;
            rtd_p1 <= '0;
            rd_p1  <= ZERO_REG;
            wr_p1  <= 1'b0;
        end else if (accept) begin
            rsd_p1 <= rsd_p0;
            rtd_p1 <= rtd_p0;
            rd_p1  <= bus.iss_rd;
            wr_p1  <= bus.iss_wr;
        end
    end

    assign bus.op_valid = (state_q == FULL);
    assign bus.op_rsd   = rsd_p1;
    assign bus.op_rtd   = rtd_p1;
    assign bus.op_rd    = rd_p1;
    assign bus.op_wr    = wr_p1;
    assign stall_cnt    = stall_q;

endmodule
